// File: rtl/pstats_rd_pkg.sv
// Shared constants, FSM state type and CR word builder for the pstats Wishbone reader.
package pstats_rd_pkg;

  localparam logic [2:0]  c_PSTATS_CR   = 3'd0;
  localparam logic [2:0]  c_PSTATS_DR   = 3'd1;
  localparam int unsigned c_CR_RDEN_BIT = 0;
  localparam int unsigned c_CR_ADR_LSB  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWrCr,
    StWrAck,
    StRdCr,
    StCrAck,
    StRdDr,
    StDrAck,
    StPush
  } t_rd_state;

  function automatic logic [31:0] cr_word(input logic [15:0] row);
    logic [31:0] w;
    w = 32'(row) << c_CR_ADR_LSB;
    w[c_CR_RDEN_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/pstats_wb_reader_if.sv
// Wishbone pipelined bus between the pstats reader (master) and wrsw_pstats (slave).
interface pstats_wb_reader_if;
  logic [2:0]  adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        ack;
  logic        stall;

  modport master (
    output adr, dat_o, cyc, stb, we, sel,
    input  dat_i, ack, stall
  );

  modport slave (
    input  adr, dat_o, cyc, stb, we, sel,
    output dat_i, ack, stall
  );
endinterface

// File: rtl/pstats_wb_single.sv
// Single-beat pipelined Wishbone access engine; a req pulse while idle starts one access.
// Define PSTATS_RD_TIMEOUT_EN to enable the per-access ack watchdog (g_ack_timeout cycles).
module pstats_wb_single #(
  parameter int unsigned g_ack_timeout = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [2:0]         adr_i,
  input  logic [31:0]        dat_i,
  output logic               done_o,
  output logic               timeout_o,
  output logic [31:0]        rdata_o,
  pstats_wb_reader_if.master wb
);

  if (g_ack_timeout == 0) begin : g_bad_timeout
    $error("g_ack_timeout must be nonzero");
  end

  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        expire;

`ifdef PSTATS_RD_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(g_ack_timeout + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(g_ack_timeout - 1);

  logic [WdW-1:0] wd_q;

  // Counts cycles since cyc rose; zero whenever the bus is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cyc_q) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  assign expire = cyc_q && !wb.ack && (wd_q == WdLast);
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (!cyc_q) begin
      if (req_i) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        dat_d = dat_i;
      end
    end else if (wb.ack || expire) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end else if (stb_q && !wb.stall) begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel   = 4'b1111;

  // An ack outside our own cycle (e.g. after reset) is not ours.
  assign done_o    = cyc_q && wb.ack;
  assign timeout_o = expire;
  assign rdata_o   = wb.dat_i;

endmodule

// File: rtl/pstats_wb_reader.sv
// Hardware sweeper for wrsw_pstats: per row write CR, poll RD_EN until clear, read DR, stream out.
// PSTATS_RD_TIMEOUT_EN enables an ack watchdog inside pstats_wb_single.
module pstats_wb_reader
  import pstats_rd_pkg::*;
#(
  parameter int unsigned g_nrows       = 16,
  parameter int unsigned g_row_w       = 8,
  parameter int unsigned g_poll_max    = 15,
  parameter int unsigned g_ack_timeout = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [g_row_w-1:0] row_o,
  output logic [31:0]        data_o,
  output logic               valid_o,
  input  logic               ready_i,
  pstats_wb_reader_if.master wb
);

  localparam int unsigned PollW = $clog2(g_poll_max + 1);
  localparam logic [g_row_w-1:0] LastRow = g_row_w'(g_nrows - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(g_poll_max - 1);

  t_rd_state           state_q, state_d;
  logic [g_row_w-1:0]  row_q, row_d;
  logic [PollW-1:0]    poll_q, poll_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [g_row_w-1:0]  row_out_q, row_out_d;
  logic [31:0]         data_q, data_d;

  logic        acc_req;
  logic        acc_we;
  logic [2:0]  acc_adr;
  logic [31:0] acc_dat;
  logic        acc_done;
  logic        acc_timeout;
  logic [31:0] acc_rdata;

  pstats_wb_single #(
    .g_ack_timeout(g_ack_timeout)
  ) u_single (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (acc_req),
    .we_i      (acc_we),
    .adr_i     (acc_adr),
    .dat_i     (acc_dat),
    .done_o    (acc_done),
    .timeout_o (acc_timeout),
    .rdata_o   (acc_rdata),
    .wb        (wb)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    poll_d    = poll_q;
    err_d     = err_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    row_out_d = row_out_q;
    data_d    = data_q;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = c_PSTATS_CR;
    acc_dat   = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d   = 1'b0;
          row_d   = '0;
          state_d = StWrCr;
        end
      end
      StWrCr: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_dat = cr_word(16'(row_q));
        poll_d  = '0;
        state_d = StWrAck;
      end
      StWrAck: begin
        if (acc_done) state_d = StRdCr;
      end
      StRdCr: begin
        acc_req = 1'b1;
        state_d = StCrAck;
      end
      StCrAck: begin
        if (acc_done) begin
          if (!acc_rdata[c_CR_RDEN_BIT]) begin
            state_d = StRdDr;
          end else if (poll_q == PollLast) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            poll_d  = poll_q + PollW'(1);
            state_d = StRdCr;
          end
        end
      end
      StRdDr: begin
        acc_req = 1'b1;
        acc_adr = c_PSTATS_DR;
        state_d = StDrAck;
      end
      StDrAck: begin
        if (acc_done) begin
          data_d    = acc_rdata;
          row_out_d = row_q;
          valid_d   = 1'b1;
          state_d   = StPush;
        end
      end
      StPush: begin
        if (ready_i) begin
          valid_d = 1'b0;
          if (row_q == LastRow) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            row_d   = row_q + g_row_w'(1);
            state_d = StWrCr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog expiry aborts the sweep from any access-wait state.
    if (acc_timeout && (state_q inside {StWrAck, StCrAck, StDrAck})) begin
      err_d   = 1'b1;
      done_d  = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      row_q     <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      row_out_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      row_out_q <= row_out_d;
      data_q    <= data_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;
  assign row_o   = row_out_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_pstats_wb_reader.sv
// Directed bench for pstats_wb_reader with a reactive wrsw_pstats slave model.
module tb_pstats_wb_reader;
  import pstats_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy, done, err, valid;
  logic [7:0]  row;
  logic [31:0] data;

  pstats_wb_reader_if wb ();

  pstats_wb_reader #(
    .g_nrows      (16),
    .g_row_w      (8),
    .g_poll_max   (15),
    .g_ack_timeout(255)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .row_o  (row),
    .data_o (data),
    .valid_o(valid),
    .ready_i(ready),
    .wb     (wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Slave model configuration and logs
  int  stall_n   = 0;
  int  busy_row  = -1;
  int  busy_n    = 0;
  bit  stuck     = 1'b0;
  bit  never_ack = 1'b0;
  int  cur_row   = 0;
  int  cr_reads[16];
  int  stall_cycles = 0, stb_cycles = 0, unstable = 0, late_stb = 0;
  logic [31:0] wr_log[$];
  logic [2:0]  wr_adr_log[$];

  // Monitor logs
  logic [7:0]  beat_row[$];
  logic [31:0] beat_data[$];
  int   done_cnt = 0, cyc_no = 0, start_cyc = 0, done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic prev_cyc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: zero-latency decode, configurable stall, ack one cycle after stb is accepted.
  initial begin
    bit          in_acc, ack_next;
    int          stall_left;
    logic [2:0]  a_adr;
    logic [31:0] a_dat, resp;
    in_acc = 1'b0; ack_next = 1'b0; stall_left = 0; a_adr = '0; a_dat = '0; resp = '0;
    wb.ack = 1'b0; wb.stall = 1'b0; wb.dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wb.ack   = 1'b0;
      wb.stall = 1'b0;
      if (rst) begin
        in_acc = 1'b0; ack_next = 1'b0;
      end else if (ack_next) begin
        if (wb.stb) late_stb++;
        wb.ack   = !never_ack;
        wb.dat_i = resp;
        ack_next = 1'b0;
        in_acc   = 1'b0;
      end else if (wb.cyc && wb.stb) begin
        stb_cycles++;
        if (!in_acc) begin
          in_acc = 1'b1; stall_left = stall_n; a_adr = wb.adr; a_dat = wb.dat_o; resp = '0;
          if (wb.we) begin
            wr_log.push_back(wb.dat_o);
            wr_adr_log.push_back(wb.adr);
            cur_row = int'(wb.dat_o[19:16]);
          end else if (wb.adr == c_PSTATS_CR) begin
            resp[0] = stuck || (cur_row == busy_row && cr_reads[cur_row] < busy_n);
            cr_reads[cur_row]++;
          end else begin
            resp = 32'hA0 + 32'(cur_row);
          end
        end else if (wb.adr !== a_adr || wb.dat_o !== a_dat) begin
          unstable++;
        end
        if (stall_left > 0) begin
          wb.stall = 1'b1; stall_left--; stall_cycles++;
        end else begin
          ack_next = 1'b1;
        end
      end
    end
  end

  // Stream/done/cyc monitor on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      if (start) start_cyc = cyc_no;
      if (done) begin done_cnt++; done_cyc = cyc_no; end
      if (valid && ready) begin beat_row.push_back(row); beat_data.push_back(data); end
      if (wb.cyc && !prev_cyc) rise_cyc = cyc_no;
      if (!wb.cyc && prev_cyc) fall_cyc = cyc_no;
      prev_cyc = wb.cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic clear_logs();
    wr_log.delete(); wr_adr_log.delete(); beat_row.delete(); beat_data.delete();
    foreach (cr_reads[i]) cr_reads[i] = 0;
    done_cnt = 0; stall_cycles = 0; stb_cycles = 0; unstable = 0; late_stb = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    @(posedge clk); #1;
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_beats"}, beat_row.size(), 16);
    for (int i = 0; i < beat_row.size() && i < 16; i++) begin
      chk({tag, "_row"}, beat_row[i], i);
      chk({tag, "_data"}, beat_data[i], 32'hA0 + i);
    end
  endtask

  initial begin
    int hold_bad;
    int n;
    foreach (cr_reads[i]) cr_reads[i] = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", valid, 0);
    chk("rst_row", row, 0);
    chk("rst_data", data, 0);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_we", wb.we, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_dat", wb.dat_o, 0);
    chk("rst_sel", wb.sel, 32'hF);

    // Basic sweep, no stall
    @(posedge clk); #1;
    clear_logs();
    pulse_start();
    wait_done("s1_finish", 400);
    check_stream("s1");
    chk("s1_wr_count", wr_log.size(), 16);
    for (int i = 0; i < wr_log.size() && i < 16; i++) begin
      chk("s1_wr_dat", wr_log[i], (i << 16) | 1);
      chk("s1_wr_adr", wr_adr_log[i], 0);
    end
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_err", err, 0);
    chk("s1_busy", busy, 0);
    chk("s1_latency", done_cyc - start_cyc, 161);
    chk("s1_late_stb", late_stb, 0);

    // Stall 3 cycles per access; a second start mid-sweep is ignored
    stall_n = 3;
    clear_logs();
    pulse_start();
    repeat (30) @(posedge clk);
    #1;
    pulse_start();
    wait_done("s2_finish", 1000);
    check_stream("s2");
    chk("s2_stall_cycles", stall_cycles, 144);
    chk("s2_stb_cycles", stb_cycles, 192);
    chk("s2_unstable", unstable, 0);
    chk("s2_done_cnt", done_cnt, 1);
    stall_n = 0;

    // Row 5: CR RD_EN reads busy four times
    busy_row = 5; busy_n = 4;
    clear_logs();
    pulse_start();
    wait_done("s3_finish", 500);
    chk("s3_cr_reads_r5", cr_reads[5], 5);
    chk("s3_cr_reads_r4", cr_reads[4], 1);
    check_stream("s3");
    chk("s3_err", err, 0);
    busy_row = -1; busy_n = 0;

    // RD_EN stuck: poll limit error
    stuck = 1'b1;
    clear_logs();
    pulse_start();
    wait_done("s4_finish", 400);
    chk("s4_err", err, 1);
    chk("s4_done_cnt", done_cnt, 1);
    chk("s4_done_pulse", done, 0);
    chk("s4_busy", busy, 0);
    chk("s4_cr_reads", cr_reads[0], 15);
    chk("s4_beats", beat_row.size(), 0);
    stuck = 1'b0;

    // Back-pressure on row 3 for 20 cycles
    clear_logs();
    pulse_start();
    chk("s5_err_clr", err, 0);
    chk("s5_busy", busy, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(valid === 1'b1 && row === 8'd2) && n < 200);
    @(posedge clk); #1;
    ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (valid !== 1'b1 && n < 100);
    hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (valid !== 1'b1 || row !== 8'd3 || data !== 32'hA3 || wb.cyc !== 1'b0) hold_bad++;
    end
    @(posedge clk); #1;
    ready = 1'b1;
    chk("s5_hold", hold_bad, 0);
    wait_done("s5_finish", 400);
    check_stream("s5");

    // Reset during an access on row 7, then a fresh sweep
    clear_logs();
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!(wb.cyc === 1'b1 && cur_row == 7) && n < 300);
    chk("s6_reached_r7", 32'(n < 300), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s6_cyc", wb.cyc, 0);
    chk("s6_stb", wb.stb, 0);
    chk("s6_busy", busy, 0);
    chk("s6_valid", valid, 0);
    chk("s6_done", done, 0);
    chk("s6_adr", wb.adr, 0);
    chk("s6_dat", wb.dat_o, 0);
    chk("s6_data", data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    pulse_start();
    wait_done("s6_finish", 400);
    check_stream("s6");
    chk("s6_first_wr", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD, 32'h1);
    chk("s6_done_cnt", done_cnt, 1);

`ifdef PSTATS_RD_TIMEOUT_EN
    never_ack = 1'b1;
    clear_logs();
    pulse_start();
    wait_done("s7_finish", 400);
    chk("s7_cyc_len", fall_cyc - rise_cyc, 255);
    chk("s7_err", err, 1);
    chk("s7_done_cnt", done_cnt, 1);
    never_ack = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
